// File: rtl/scratch_fill_writer_pkg.sv
// Shared types, default sizes and the wrap-increment helper for the scratchpad fill writer.
package scratch_fill_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam int CELL_SIZE_DEF    = 8;
  localparam int ADDRESS_SIZE_DEF = 8;
  localparam int CELL_NUMS_DEF    = 8;
  localparam int PTR_SIZE         = ADDRESS_SIZE_DEF + 1;

  function automatic int ptr_size(input int address_size);
    return address_size + 1;
  endfunction

  // Pointer = {wrap bit, index}; the index wraps at cell_nums-1, which need not be a power of two.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                           input int          address_size,
                                           input int          cell_nums);
    logic [31:0] idx;
    logic [31:0] wrap_bit;
    idx      = ptr & ((32'd1 << address_size) - 32'd1);
    wrap_bit = (ptr >> address_size) & 32'd1;
    if (idx == 32'(cell_nums - 1)) begin
      idx      = '0;
      wrap_bit = wrap_bit ^ 32'd1;
    end else begin
      idx = idx + 32'd1;
    end
    return (wrap_bit << address_size) | idx;
  endfunction

endpackage

// File: rtl/scratch_fill_writer_wrap_ptr.sv
// scratch_wrap_ptr: wrap-tagged circular pointer with an increment enable.
module scratch_wrap_ptr
  import scratch_fill_writer_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int CELL_NUMS    = CELL_NUMS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDRESS_SIZE:0] ptr
);

  localparam int PW = ptr_size(ADDRESS_SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PW'(wrap_inc(32'(ptr), ADDRESS_SIZE, CELL_NUMS));
    end
  end

endmodule

// File: rtl/scratch_fill_writer.sv
// Write-side controller for one scratchpad buffer: stream accept, write strobes, free-slot tracking.
// Optional sticky protocol-error output enabled by defining SCRATCH_FILL_ERR_EN.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting stream words while slots are free
// FLUSH | last word taken, waiting for reader to drain the buffer
// DONE  | one-cycle completion pulse
module scratch_fill_writer
  import scratch_fill_writer_pkg::*;
#(
  parameter int CELL_SIZE    = CELL_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int CELL_NUMS    = CELL_NUMS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [CELL_SIZE-1:0]    in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDRESS_SIZE-1:0] wr_addr,
  output logic [CELL_SIZE-1:0]    wr_data,
  output logic                    write_cnt,
  output logic [ADDRESS_SIZE:0]   write_addr,
  input  logic                    slot_release,
  output logic [ADDRESS_SIZE:0]   fill_level,
  output logic                    full,
  output logic                    empty,
  output logic                    busy,
`ifdef SCRATCH_FILL_ERR_EN
  output logic                    err,
`endif
  output logic                    done
);

  localparam int PW = ptr_size(ADDRESS_SIZE);

  fill_state_t           state, state_nxt;
  logic [ADDRESS_SIZE:0] wr_ptr, rel_ptr;
  logic                  accept, rel_ok;

  scratch_wrap_ptr #(.ADDRESS_SIZE(ADDRESS_SIZE), .CELL_NUMS(CELL_NUMS)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .ptr (wr_ptr)
  );

  scratch_wrap_ptr #(.ADDRESS_SIZE(ADDRESS_SIZE), .CELL_NUMS(CELL_NUMS)) u_rel_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rel_ok),
    .ptr (rel_ptr)
  );

  // Differing wrap bits mean the writer is one lap ahead of the reader.
  always_comb begin
    fill_level = '0;
    if (wr_ptr[ADDRESS_SIZE] == rel_ptr[ADDRESS_SIZE]) begin
      fill_level = PW'(wr_ptr[ADDRESS_SIZE-1:0]) - PW'(rel_ptr[ADDRESS_SIZE-1:0]);
    end else begin
      fill_level = PW'(CELL_NUMS) + PW'(wr_ptr[ADDRESS_SIZE-1:0]) - PW'(rel_ptr[ADDRESS_SIZE-1:0]);
    end
  end

  assign full   = (fill_level == PW'(CELL_NUMS));
  assign empty  = (fill_level == '0);
  assign rel_ok = slot_release & ~empty;
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = ~full;
        if (in_valid && !full && in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en      = accept;
  assign write_cnt  = accept;
  assign wr_addr    = wr_ptr[ADDRESS_SIZE-1:0];
  assign wr_data    = accept ? in_data : '0;
  assign write_addr = wr_ptr;
  assign busy       = (state != IDLE);

`ifdef SCRATCH_FILL_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((slot_release && empty) || (start && busy) || (in_valid && state == FLUSH)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scratch_fill_writer.sv
// Randomized and directed bench for scratch_fill_writer against a word-count reference model.
module tb_scratch_fill_writer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, in_last, slot_release;
  logic [7:0] in_data;
  logic       in_ready, wr_en, write_cnt, full, empty, busy, done;
  logic [7:0] wr_addr, wr_data;
  logic [8:0] write_addr, fill_level;
`ifdef SCRATCH_FILL_ERR_EN
  logic       err;
`endif

  scratch_fill_writer #(.CELL_SIZE(8), .ADDRESS_SIZE(8), .CELL_NUMS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .write_cnt    (write_cnt),
    .write_addr   (write_addr),
    .slot_release (slot_release),
    .fill_level   (fill_level),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
`ifdef SCRATCH_FILL_ERR_EN
    .err          (err),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  // Reference: total words written/released and a coarse phase (0 idle, 1 fill, 2 flush, 3 done).
  int m_wr, m_rel, m_phase;
  bit m_err;
  int wc_pulses, done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int fill;
    bit ex_full, ex_ready, ex_acc;
    fill     = m_wr - m_rel;
    ex_full  = (fill == N);
    ex_ready = (m_phase == 1) && !ex_full;
    ex_acc   = ex_ready && in_valid;
    chk("in_ready",   32'(in_ready),   32'(ex_ready));
    chk("wr_en",      32'(wr_en),      32'(ex_acc));
    chk("write_cnt",  32'(write_cnt),  32'(ex_acc));
    chk("wr_addr",    32'(wr_addr),    32'(m_wr % N));
    chk("wr_data",    32'(wr_data),    ex_acc ? 32'(in_data) : 32'd0);
    chk("write_addr", 32'(write_addr), 32'((((m_wr / N) % 2) << 8) + (m_wr % N)));
    chk("fill_level", 32'(fill_level), 32'(fill));
    chk("full",       32'(full),       32'(ex_full));
    chk("empty",      32'(empty),      32'(fill == 0));
    chk("busy",       32'(busy),       32'(m_phase != 0));
    chk("done",       32'(done),       32'(m_phase == 3));
`ifdef SCRATCH_FILL_ERR_EN
    chk("err",        32'(err),        32'(m_err));
`endif
    if (write_cnt) wc_pulses++;
    if (done) done_cnt++;
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d, input bit l, input bit r);
    int  fill;
    bit  acc;
    @(negedge clk);
    start = s; in_valid = v; in_data = d; in_last = l; slot_release = r;
    #1;
    check_all();
    @(posedge clk);
    fill = m_wr - m_rel;
    acc  = (m_phase == 1) && (fill != N) && v;
    if ((r && fill == 0) || (s && m_phase != 0) || (v && m_phase == 2)) m_err = 1'b1;
    case (m_phase)
      0: if (s) m_phase = 1;
      1: if (acc && l) m_phase = 2;
      2: if (fill == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (acc) m_wr++;
    if (r && fill > 0) m_rel++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 0; in_valid = 0; in_data = '0; in_last = 0; slot_release = 0;
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_fill",       32'(fill_level), 32'd0);
    chk("rst_empty",      32'(empty),      32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    m_wr = 0; m_rel = 0; m_phase = 0; m_err = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 0; in_valid = 0; in_data = '0; in_last = 0; slot_release = 0;
    m_wr = 0; m_rel = 0; m_phase = 0; m_err = 0; wc_pulses = 0; done_cnt = 0;
    do_reset();

`ifdef SCRATCH_FILL_ERR_EN
    step(0, 0, 8'h00, 0, 1);
    #1;
    chk("err_rel_empty", 32'(err), 32'd1);
    chk("err_fill_zero", 32'(fill_level), 32'd0);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    #1;
    chk("err_restart", 32'(err), 32'd1);
    chk("err_still_fill", 32'(in_ready), 32'd1);
    do_reset();
`endif

    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0);
    do_reset();

    step(1, 0, 8'h00, 0, 0);
    wc_pulses = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    step(0, 1, 8'h55, 0, 0);
    chk("wcnt_pulses", 32'(wc_pulses), 32'd8);
    #1;
    chk("full_after_8",   32'(full),       32'd1);
    chk("ready_full",     32'(in_ready),   32'd0);
    chk("waddr_wrapped",  32'(write_addr), 32'h100);

    step(0, 0, 8'h00, 0, 1);
    #1;
    chk("ready_after_rel", 32'(in_ready),   32'd1);
    chk("wrap_wr_addr",    32'(wr_addr),    32'd0);
    step(0, 1, 8'h18, 0, 0);
    #1;
    chk("refill_level",    32'(fill_level), 32'd8);
    chk("refill_waddr",    32'(write_addr), 32'h101);

    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h19, 0, 1);
    #1;
    chk("acc_rel_fill",  32'(fill_level), 32'd4);
    chk("acc_rel_waddr", 32'(write_addr), 32'h102);

    step(0, 1, 8'h1A, 1, 0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0);
    chk("done_once_a", 32'(done_cnt), 32'd1);
    #1;
    chk("idle_after_a", 32'(busy), 32'd0);

    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h31, 0, 0);
    step(0, 1, 8'h32, 0, 0);
    step(0, 1, 8'h33, 1, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 0);
    chk("done_once_b", 32'(done_cnt), 32'd1);
    #1;
    chk("idle_after_b", 32'(busy), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
